// File: rtl/cpu_multicycle.sv
// Multi-cycle RISC-V subset core. FETCH/DECODE/EXEC/WB sequencing with a
// wait-state tolerant instruction port and a registered retire trace.
module cpu_multicycle #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic            retire_o,
  output logic [XLEN-1:0] retire_pc_o,
  output logic [4:0]      retire_rd_o,
  output logic [XLEN-1:0] retire_data_o,
  output logic            illegal_o,
  output logic            halted_o
);
  localparam int         SW     = $clog2(XLEN);
  localparam int         AW     = $clog2(NREG);
  localparam logic [5:0] NREG_W = 6'(NREG);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ILL, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_MUL, OP_ADDI, OP_SRAI
  } op_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_pc, r_op_a, r_op_b, r_imm, r_result;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_regs [NREG];

  logic            r_retire, r_illegal;
  logic [XLEN-1:0] r_retire_pc, r_retire_data;
  logic [4:0]      r_retire_rd;

  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd_f, w_rs1_f, w_rs2_f;
  logic [AW-1:0]   w_rd_idx, w_rs1_idx, w_rs2_idx;
  logic [SW-1:0]   w_shamt_r, w_shamt_i;
  op_t             w_op;
  logic            w_uses_rs2, w_reg_oob, w_legal, w_wen;
  logic [XLEN-1:0] w_alu;

  assign w_opcode  = r_ir[6:0];
  assign w_rd_f    = r_ir[11:7];
  assign w_funct3  = r_ir[14:12];
  assign w_rs1_f   = r_ir[19:15];
  assign w_rs2_f   = r_ir[24:20];
  assign w_funct7  = r_ir[31:25];
  assign w_rd_idx  = w_rd_f[AW-1:0];
  assign w_rs1_idx = w_rs1_f[AW-1:0];
  assign w_rs2_idx = w_rs2_f[AW-1:0];
  assign w_shamt_r = r_op_b[SW-1:0];
  assign w_shamt_i = r_ir[20+SW-1:20];

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_op       = OP_ILL;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      7'b0110011: begin
        w_uses_rs2 = 1'b1;
        case ({w_funct7, w_funct3})
          10'b0000000_111: w_op = OP_AND;
          10'b0000000_100: w_op = OP_XOR;
          10'b0000000_001: w_op = OP_SLL;
          10'b0000000_000: w_op = OP_ADD;
          10'b0100000_000: w_op = OP_SUB;
          10'b0000001_000: w_op = OP_MUL;
          default:         w_op = OP_ILL;
        endcase
      end
      7'b0010011: begin
        if (w_funct3 == 3'b000)
          w_op = OP_ADDI;
        else if (w_funct3 == 3'b101 && w_funct7 == 7'b0100000)
          w_op = OP_SRAI;
      end
      default: w_op = OP_ILL;
    endcase
  end

  // rs2 is only a register index for R-type; in I-type those bits are immediate.
  assign w_reg_oob = ({1'b0, w_rs1_f} >= NREG_W) || ({1'b0, w_rd_f} >= NREG_W) ||
                     (w_uses_rs2 && ({1'b0, w_rs2_f} >= NREG_W));
  assign w_legal   = (w_op != OP_ILL) && !w_reg_oob;
  assign w_wen     = w_legal && (w_rd_f != 5'd0);

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_op_a + r_op_b;
      OP_SUB:  w_alu = r_op_a - r_op_b;
      OP_AND:  w_alu = r_op_a & r_op_b;
      OP_XOR:  w_alu = r_op_a ^ r_op_b;
      OP_SLL:  w_alu = r_op_a << w_shamt_r;
      OP_MUL:  w_alu = r_op_a * r_op_b;
      OP_ADDI: w_alu = r_op_a + r_imm;
      OP_SRAI: w_alu = XLEN'($signed(r_op_a) >>> w_shamt_i);
      default: w_alu = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_next = S_FETCH;
      S_FETCH:  if (imem_ack_i) w_next = S_DECODE;
      S_DECODE: w_next = (r_ir == 32'h0) ? S_HALT : S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = start_i ? S_FETCH : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: the register file is reset because architectural state must start at zero; a plain RAM would not be.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_imm    <= '0;
      r_result <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (imem_ack_i) r_ir <= imem_data_i;
        S_DECODE: begin
          r_op_a <= r_regs[w_rs1_idx];
          r_op_b <= r_regs[w_rs2_idx];
          r_imm  <= {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        end
        S_EXEC: r_result <= w_alu;
        S_WB: begin
          if (w_wen) r_regs[w_rd_idx] <= r_result;
          r_pc <= r_pc + XLEN'(4);
        end
        default: ;
      endcase
    end
  end

  // EXEC always leads to WB, so loading the trace here makes it valid exactly in WB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_retire      <= 1'b0;
      r_retire_pc   <= '0;
      r_retire_rd   <= '0;
      r_retire_data <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_retire      <= (r_state == S_EXEC);
      r_retire_pc   <= (r_state == S_EXEC) ? r_pc : '0;
      r_retire_rd   <= (r_state == S_EXEC && w_wen) ? w_rd_f : '0;
      r_retire_data <= (r_state == S_EXEC && w_wen) ? w_alu : '0;
      r_illegal     <= (r_state == S_EXEC) && !w_legal;
    end
  end

  assign imem_req_o    = (r_state == S_FETCH);
  assign imem_addr_o   = r_pc;
  assign halted_o      = (r_state == S_HALT);
  assign retire_o      = r_retire;
  assign retire_pc_o   = r_retire_pc;
  assign retire_rd_o   = r_retire_rd;
  assign retire_data_o = r_retire_data;
  assign illegal_o     = r_illegal;

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle RISC-V subset core. One instruction is fetched, decoded, executed and written back over at least four cycles under a state machine. Instruction fetch uses an external request/acknowledge memory port that tolerates wait states. A retire trace port is provided for the bench.

## Interface
Parameters:
- XLEN, 32: datapath and register width; must be 32 or 64.
- NREG, 32: number of architectural registers; power of two, 2..32.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  run enable; sampled in IDLE and WB.
- imem_req_o  output  1  fetch request; held high until acknowledged.
- imem_addr_o  output  XLEN  byte address of the fetch (the PC).
- imem_ack_i  input  1  fetch acknowledge; imem_data_i is valid in the same cycle.
- imem_data_i  input  32  instruction word.
- retire_o  output  1  one-cycle pulse per completed instruction.
- retire_pc_o  output  XLEN  PC of the retiring instruction.
- retire_rd_o  output  5  destination index written; 0 if no write.
- retire_data_o  output  XLEN  value written; 0 if no write.
- illegal_o  output  1  one-cycle pulse, coincident with retire_o, for an unsupported encoding.
- halted_o  output  1  high once the HALT state is entered.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- **IDLE:** go to FETCH when start_i=1; otherwise stay.
- **FETCH:** imem_req_o=1 and imem_addr_o=PC. On imem_ack_i=1, latch imem_data_i into the IR and go to DECODE. Otherwise stay, with address stable.
- **DECODE:**
  - An IR of 32'h00000000 goes to HALT. No retire.
  - Otherwise read rs1 and rs2 into operand registers and build the immediate: IR[31:20] sign-extended to XLEN. Go to EXEC.
- **EXEC:** latch the ALU result. Go to WB.
- **WB:**
  - Write rd if the instruction is legal and rd≠0.
  - PC ← PC+4, modulo 2^XLEN.
  - Pulse retire_o.
  - Go to FETCH if start_i=1, else IDLE.
- **HALT:** terminal. halted_o=1 and imem_req_o=0 until rst_i.
- Supported, opcode 0110011, selected by {funct7,funct3}:
  - and 0000000/111
  - xor 0000000/100
  - sll 0000000/001
  - add 0000000/000
  - sub 0100000/000
  - mul 0000001/000
- Supported, opcode 0010011:
  - addi, funct3 000.
  - srai, funct3 101 with IR[31:25]=0100000.
- Arithmetic:
  - Results are truncated to XLEN; mul keeps the low XLEN bits.
  - sll shift amount = rs2[log2(XLEN)-1:0]; srai shift amount = IR[20+log2(XLEN)-1:20]. srai is an arithmetic shift.
- Register x0 reads 0 and writes to it are discarded.
- Illegal instructions are retired as a NOP with illegal_o=1. Illegal means any other opcode/funct combination, or rs1, rs2 or rd ≥ NREG. There is no register write, retire_rd_o=0 and the PC still advances.

## Timing
- Reset values:
  - state=IDLE, PC=RESET_PC, all registers 0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - retire_o=0, retire_pc_o=0, retire_rd_o=0, retire_data_o=0, illegal_o=0, halted_o=0.
- Reset asserted mid-fetch: imem_req_o drops immediately (asynchronously), and any pending ack is ignored.
- Latency with zero wait states (ack in the first FETCH cycle): 4 cycles per instruction, so retire_o is asserted every 4th cycle. Each wait cycle adds one.
- retire_* outputs are registered, valid during the WB cycle only, and 0 otherwise.
- A register written in WB is visible to the next instruction's DECODE. No forwarding is needed.
- start_i deasserted during FETCH/DECODE/EXEC: the instruction completes; the core then parks in IDLE with the PC already advanced.
- imem_ack_i outside FETCH is ignored.
- PC wrap: all-ones-minus-3 + 4 → 0. No exception.

## Test plan
- **Arithmetic sequence:** XLEN=32, zero-wait memory; program addi x1,x0,5; addi x2,x0,-3; mul x3,x1,x2; sub x4,x1,x2.
  - Required: retires at cycles 4/8/12/16.
  - Required: x3=0xFFFFFFF1, x4=0x00000008.
- **Wait states:** ack delayed 3 cycles on every fetch.
  - Required: imem_addr_o stable while waiting.
  - Required: retire spacing 7 cycles.
  - Required: results identical to the zero-wait run.
- **Shifts and x0:** x1=0x80000000, srai x2,x1,4 → x2=0xF8000000. sll with rs2=33 shifts by 1. addi x0,x0,7 → x0 still reads 0.
- **Illegal encodings:** NREG=16 with rd=20; separately opcode 0x7F.
  - Required: illegal_o pulses with retire_o, retire_rd_o=0.
  - Required: the PC advances by 4 and no register changes.
- **Halt and reset mid-operation:** word 0 at PC 0x10 → halted_o=1 and imem_req_o stays 0. Then assert rst_i mid-FETCH of a new run → all outputs return to reset values in the same cycle, and the PC restarts at RESET_PC.
- **start_i gating and XLEN=64:** drop start_i during EXEC → instruction retires and the core idles with PC+4. In the XLEN=64 build, addi with imm 0x800 → 0xFFFFFFFFFFFFF800.
